// File: rtl/rob_pkg.sv
// Shared definitions for the commit/retire slice: register file geometry,
// data width and the retirement FSM state encoding.
package rob_pkg;

  localparam int REG_IDX_W = 6;
  localparam int DATA_W    = 32;
  localparam int NUM_REGS  = 64;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]    data_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FLUSH
  } retire_state_t;

endpackage

// File: rtl/commit_retire_unit_arch_regfile.sv
// Architectural register file: NUM_REGS x DATA_W, two combinational read
// ports, one write port, register 0 hardwired to zero, same-cycle
// write-to-read bypass and asynchronous clear of every entry.
module arch_regfile
  import rob_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     i_wr_en,
  input  reg_idx_t i_wr_addr,
  input  data_t    i_wr_data,
  input  reg_idx_t i_rd_addr_a,
  input  reg_idx_t i_rd_addr_b,
  output data_t    o_rd_data_a,
  output data_t    o_rd_data_b
);

  data_t r_regs [NUM_REGS];
  logic  w_hit_a;
  logic  w_hit_b;

  // Storage update: clear everything on reset, otherwise write non-zero targets.
  // NOTE: this storage is flops, not a RAM macro, because a reset must clear
  // architectural state at once; a RAM would need a multi-cycle scrub instead.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_wr_en && (i_wr_addr != '0)) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  // A result landing this cycle is forwarded so readers never see stale data.
  assign w_hit_a = i_wr_en && (i_wr_addr == i_rd_addr_a);
  assign w_hit_b = i_wr_en && (i_wr_addr == i_rd_addr_b);

  assign o_rd_data_a = (i_rd_addr_a == '0) ? '0 :
                       w_hit_a             ? i_wr_data : r_regs[i_rd_addr_a];
  assign o_rd_data_b = (i_rd_addr_b == '0) ? '0 :
                       w_hit_b             ? i_wr_data : r_regs[i_rd_addr_b];

endmodule

// File: rtl/commit_retire_unit.sv
// Commit/retire unit: requests pops from the reorder buffer via `commit`,
// retires returned results into the architectural register file and exposes
// two read ports. Optional feature macro: RETIRE_STATS_EN adds a 32-bit
// free-running retire_count output.
module commit_retire_unit
  import rob_pkg::*;
#(
  parameter int unsigned FLUSH_HOLD = 2
)(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              retire_en,
  input  logic              flush,
  output logic              commit,
  input  logic              commit_valid,
  input  logic [REG_IDX_W-1:0] commit_reg,
  input  logic [DATA_W-1:0] commit_value,
  input  logic [REG_IDX_W-1:0] rd_addr_a,
  input  logic [REG_IDX_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              retired
`ifdef RETIRE_STATS_EN
  ,
  output logic [31:0]       retire_count
`endif
);

  localparam int CNT_W = $clog2(FLUSH_HOLD + 1);

  retire_state_t    r_state;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             r_retired;

  // Retirement FSM with flush hold-off; a flush always wins and reloads the hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_flush_cnt <= '0;
    end else if (flush) begin
      r_state     <= FLUSH;
      r_flush_cnt <= CNT_W'(FLUSH_HOLD);
    end else begin
      case (r_state)
        IDLE:    if (retire_en)  r_state <= ACTIVE;
        ACTIVE:  if (!retire_en) r_state <= IDLE;
        FLUSH: begin
          if (r_flush_cnt <= CNT_W'(1)) begin
            r_state     <= IDLE;
            r_flush_cnt <= '0;
          end else begin
            r_flush_cnt <= r_flush_cnt - CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Pop request is combinational so a stall or flush suppresses it in-cycle.
  assign commit = (r_state == ACTIVE) && retire_en && !flush;

  // Results are accepted in every state: the ROB has already freed the entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_retired <= 1'b0;
    end else begin
      r_retired <= commit_valid;
    end
  end

  assign retired = r_retired;

`ifdef RETIRE_STATS_EN
  logic [31:0] r_retire_count;

  // Counts every returned result, including discarded writes to register 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_retire_count <= '0;
    end else if (commit_valid) begin
      r_retire_count <= r_retire_count + 32'd1;
    end
  end

  assign retire_count = r_retire_count;
`endif

  arch_regfile u_regfile (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_wr_en     (commit_valid),
    .i_wr_addr   (commit_reg),
    .i_wr_data   (commit_value),
    .i_rd_addr_a (rd_addr_a),
    .i_rd_addr_b (rd_addr_b),
    .o_rd_data_a (rd_data_a),
    .o_rd_data_b (rd_data_b)
  );

endmodule

// File: tb/tb_commit_retire_unit.sv
// Scoreboard bench for commit_retire_unit. Stimulus pushes expected values
// tagged with the cycle in which they must appear; a negedge monitor pops and
// compares them independently of the stimulus process.
module tb_commit_retire_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        retire_en;
  logic        flush;
  logic        commit;
  logic        commit_valid;
  logic [5:0]  commit_reg;
  logic [31:0] commit_value;
  logic [5:0]  rd_addr_a;
  logic [5:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        retired;
  logic [31:0] retire_count;

  typedef enum {K_COMMIT, K_RETIRED, K_RDA, K_RDB, K_COUNT} kind_e;
  typedef struct {
    int          cyc;
    kind_e       kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_bad  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  commit_retire_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .retire_en    (retire_en),
    .flush        (flush),
    .commit       (commit),
    .commit_valid (commit_valid),
    .commit_reg   (commit_reg),
    .commit_value (commit_value),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .retired      (retired)
`ifdef RETIRE_STATS_EN
    ,
    .retire_count (retire_count)
`endif
  );

`ifndef RETIRE_STATS_EN
  assign retire_count = '0;
`endif

  function automatic logic [31:0] sample(input kind_e k);
    case (k)
      K_COMMIT:  return {31'd0, commit};
      K_RETIRED: return {31'd0, retired};
      K_RDA:     return rd_data_a;
      K_RDB:     return rd_data_b;
      default:   return retire_count;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare every expectation due this cycle, flag any that were missed.
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < exp_q.size()) begin
      if (exp_q[i].cyc == cyc) begin
        check(exp_q[i].name, sample(exp_q[i].kind), exp_q[i].val);
        exp_q.delete(i);
      end else if (exp_q[i].cyc < cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s: never sampled, expected %h", exp_q[i].name, exp_q[i].val);
        exp_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic expect_at(input int dc, input kind_e k, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc + dc;
    e.kind = k;
    e.val  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic expect_count(input int dc, input logic [31:0] v, input string nm);
`ifdef RETIRE_STATS_EN
    expect_at(dc, K_COUNT, v, nm);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] b2b_val(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  initial begin
    reset_n      = 1'b0;
    retire_en    = 1'b0;
    flush        = 1'b0;
    commit_valid = 1'b0;
    commit_reg   = '0;
    commit_value = '0;
    rd_addr_a    = 6'd5;
    rd_addr_b    = 6'd63;

    // Reset state
    step();
    expect_at(0, K_COMMIT,  0, "rst_commit");
    expect_at(0, K_RETIRED, 0, "rst_retired");
    expect_at(0, K_RDA,     0, "rst_rd_a");
    expect_at(0, K_RDB,     0, "rst_rd_b");
    expect_count(0, 0, "rst_count");
    step();
    reset_n = 1'b1;
    step();

    // Retire 0xDEADBEEF into r5: IDLE -> ACTIVE, then result returns
    retire_en = 1'b1;
    expect_at(0, K_COMMIT, 0, "t1_idle_commit");
    step();
    expect_at(0, K_COMMIT, 1, "t1_active_commit");
    step();
    commit_valid = 1'b1; commit_reg = 6'd5; commit_value = 32'hDEADBEEF; rd_addr_a = 6'd5;
    expect_at(0, K_RDA,     32'hDEADBEEF, "t1_bypass_a");
    expect_at(0, K_RETIRED, 0,            "t1_retired_before");
    expect_at(1, K_RETIRED, 1,            "t1_retired_pulse");
    step();
    commit_valid = 1'b0; retire_en = 1'b0;
    expect_at(0, K_RDA,    32'hDEADBEEF, "t1_readback_a");
    expect_at(0, K_COMMIT, 0,            "t1_stall_commit");
    expect_count(0, 1, "t1_count");

    // Register 0 write is discarded but still retires
    step();
    commit_valid = 1'b1; commit_reg = 6'd0; commit_value = 32'h0000_1234;
    rd_addr_a = 6'd0; rd_addr_b = 6'd0;
    expect_at(0, K_RDA, 0, "t2_reg0_bypass_a");
    expect_at(0, K_RDB, 0, "t2_reg0_bypass_b");
    expect_at(1, K_RETIRED, 1, "t2_reg0_retired");
    step();
    commit_valid = 1'b0;
    expect_at(0, K_RDA, 0, "t2_reg0_after");
    expect_count(0, 2, "t2_count");
    step();
    retire_en = 1'b1;
    expect_at(0, K_RETIRED, 0, "t2_retired_drop");
    expect_at(0, K_COMMIT,  0, "t3_idle_commit");

    // Flush while ACTIVE with a result in flight the same cycle
    step();
    expect_at(0, K_COMMIT, 1, "t3_active_commit");
    step();
    flush = 1'b1; commit_valid = 1'b1; commit_reg = 6'd7; commit_value = 32'hA5A5A5A5;
    rd_addr_b = 6'd7;
    expect_at(0, K_COMMIT, 0,            "t3_flush_wins");
    expect_at(0, K_RDB,    32'hA5A5A5A5, "t3_bypass_b");
    expect_at(1, K_RETIRED, 1,           "t3_retired_in_flush");
    step();
    flush = 1'b0; commit_valid = 1'b0;
    expect_at(0, K_COMMIT, 0,            "t3_hold1");
    expect_at(0, K_RDB,    32'hA5A5A5A5, "t3_written_r7");
    expect_count(0, 3, "t3_count");
    step();
    expect_at(0, K_COMMIT, 0, "t3_hold2");
    step();
    // Back in IDLE for one cycle before retire_en takes it to ACTIVE
    expect_at(0, K_COMMIT, 0, "t3_idle_after_flush");
    step();
    expect_at(0, K_COMMIT, 1, "t3_resume");

    // Flush inside FLUSH restarts the hold count
    step();
    flush = 1'b1;
    expect_at(0, K_COMMIT, 0, "t3r_flush_a");
    step();
    flush = 1'b0;
    expect_at(0, K_COMMIT, 0, "t3r_hold_a");
    step();
    flush = 1'b1;
    expect_at(0, K_COMMIT, 0, "t3r_flush_b");
    step();
    flush = 1'b0;
    expect_at(0, K_COMMIT, 0, "t3r_hold1");
    step();
    expect_at(0, K_COMMIT, 0, "t3r_hold2");
    step();
    expect_at(0, K_COMMIT, 0, "t3r_idle");
    step();
    expect_at(0, K_COMMIT, 1, "t3r_resume");

    // Stall with a same-cycle result to r9 read on both ports
    step();
    retire_en = 1'b0; commit_valid = 1'b1; commit_reg = 6'd9; commit_value = 32'h55;
    rd_addr_a = 6'd9; rd_addr_b = 6'd9;
    expect_at(0, K_COMMIT, 0,     "t4_stall_commit");
    expect_at(0, K_RDA,    32'h55, "t4_bypass_a");
    expect_at(0, K_RDB,    32'h55, "t4_bypass_b");
    expect_at(1, K_RETIRED, 1,     "t4_retired");
    step();
    retire_en = 1'b1; commit_valid = 1'b0;
    expect_at(0, K_COMMIT, 0,     "t4_idle_reenable");
    expect_at(0, K_RDB,    32'h55, "t4_written_r9");
    expect_count(0, 4, "t4_count");
    step();
    expect_at(0, K_COMMIT, 1, "t4_commit_follows");
    step();
    retire_en = 1'b0;
    expect_at(0, K_COMMIT, 0, "t4_commit_drops");
    step();
    retire_en = 1'b1;
    expect_at(0, K_COMMIT, 0, "t4_idle_again");

    // 16 back-to-back results to r1..r16
    for (int i = 1; i <= 16; i++) begin
      step();
      commit_valid = 1'b1; commit_reg = 6'(i); commit_value = b2b_val(i);
      expect_at(0, K_COMMIT,  1, $sformatf("t5_commit_%0d", i));
      expect_at(1, K_RETIRED, 1, $sformatf("t5_retired_%0d", i));
    end
    step();
    commit_valid = 1'b0; retire_en = 1'b0;
    expect_at(1, K_RETIRED, 0, "t5_retired_end");
    // 4 earlier results plus 16 here
    expect_count(0, 20, "t5_count");
    for (int i = 1; i <= 16; i++) begin
      step();
      rd_addr_a = 6'(i); rd_addr_b = 6'(17 - i);
      expect_at(0, K_RDA, b2b_val(i),      $sformatf("t5_read_a_%0d", i));
      expect_at(0, K_RDB, b2b_val(17 - i), $sformatf("t5_read_b_%0d", 17 - i));
    end

    // Asynchronous reset between edges while a result is retiring
    step();
    retire_en = 1'b1;
    step();
    commit_valid = 1'b1; commit_reg = 6'd3; commit_value = 32'h0BADF00D;
    expect_at(0, K_COMMIT, 1, "t6_commit_before");
    step();
    commit_valid = 1'b0; rd_addr_a = 6'd3; rd_addr_b = 6'd16;
    #2 reset_n = 1'b0;
    expect_at(0, K_COMMIT,  0, "t6_rst_commit");
    expect_at(0, K_RETIRED, 0, "t6_rst_retired");
    expect_at(0, K_RDA,     0, "t6_rst_rd_a");
    expect_at(0, K_RDB,     0, "t6_rst_rd_b");
    expect_count(0, 0, "t6_rst_count");
    step();
    expect_at(0, K_RDA, 0, "t6_rst_hold_rd_a");
    step();
    reset_n = 1'b1;
    expect_at(0, K_COMMIT, 0, "t6_idle_after_rst");
    step();
    expect_at(0, K_COMMIT, 1, "t6_active_after_rst");
    expect_at(0, K_RDB,    0, "t6_cleared_r16");
    expect_at(0, K_RDA,    0, "t6_cleared_r3");

    step();
    step();
    step();
    while (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: left unchecked, expected %h", exp_q[0].name, exp_q[0].val);
      exp_q.delete(0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
